// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, frame size and the
// clocks-per-bit computation used by both the transmit and receive sides.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 10;
  localparam int BYTE_W     = 8;

  // Clocks per serial bit, truncated; callers must keep the result >= 2.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Push-side bundle between the game logic and the buffered UART transmitter.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
);
  logic                    wr_en;
  logic [BYTE_W-1:0]       wr_data;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;

  // Game logic side: pushes bytes and watches the FIFO status.
  modport master (
    output wr_en, wr_data,
    input  full, empty, count, overflow
  );

  // Transmitter side: accepts bytes and reports FIFO status.
  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count and show-ahead read data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;
  logic [CW-1:0]    count_next;

  // A push while full is dropped even if a pop frees a slot this same cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    if (do_wr && !do_rd) begin
      count_next = count + CW'(1);
    end else if (!do_wr && do_rd) begin
      count_next = count - CW'(1);
    end
  end

  // Pointer, occupancy and flag registers; flags derive from the next count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes pushed into a FIFO are sent LSB first
// at a fixed baud rate, with back-to-back frames when data is waiting.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_tx_fifo_if.slave push,
  output logic          busy,
  output logic          tx
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(DIV);

  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shift;
  logic [BYTE_W-1:0] head;
  logic              bit_end;
  logic              pop;

  assign bit_end = (baud_cnt == CNT_W'(DIV - 1));
  // Take the next byte when idle, or at the last clock of a stop bit so the
  // next start bit follows with no idle gap.
  assign pop = !push.empty && ((state == IDLE) || ((state == STOP) && bit_end));

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push.wr_en),
    .wr_data (push.wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (push.full),
    .empty   (push.empty),
    .count   (push.count)
  );

  // Flag a rejected push for exactly the cycle after it was attempted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push.overflow <= 1'b0;
    end else begin
      push.overflow <= push.wr_en && push.full;
    end
  end

  // Frame sequencer: baud timing, bit index, shift register and line drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!push.empty) begin
            shift    <= head;
            baud_cnt <= '0;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end else begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!push.empty) begin
              shift <= head;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random pushes, checked every
// cycle against a queue-based model of FIFO occupancy and line timing.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 4;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * DIV;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  logic tx;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) push_if ();

  uart_tx_fifo #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DEPTH    (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_if.slave),
    .busy    (busy),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: bytes waiting, clock index within the current frame (-1 = none),
  // byte currently on the line, expected overflow flag.
  byte unsigned mq[$];
  int           frame_t = -1;
  logic [7:0]   cur = 8'h00;
  logic         exp_ovf = 1'b0;

  function automatic logic exp_line();
    int b;
    if (frame_t < 0) return 1'b1;
    b = frame_t / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  task automatic model_clear();
    mq.delete();
    frame_t = -1;
    exp_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [7:0] d);
    logic pop_now;
    logic acc;
    if (!reset_n) begin
      model_clear();
      return;
    end
    pop_now = (mq.size() > 0) && ((frame_t < 0) || (frame_t == FRAME - 1));
    acc     = we && (mq.size() < DEPTH);
    exp_ovf = we && (mq.size() == DEPTH);
    if (pop_now) begin
      cur     = mq.pop_front();
      frame_t = 0;
    end else if (frame_t >= 0) begin
      frame_t++;
      if (frame_t == FRAME) frame_t = -1;
    end
    if (acc) mq.push_back(d);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".tx"},       32'(tx),               32'(exp_line()));
    check({tag, ".busy"},     32'(busy),             32'(frame_t >= 0));
    check({tag, ".count"},    32'(push_if.count),    32'(mq.size()));
    check({tag, ".empty"},    32'(push_if.empty),    32'(mq.size() == 0));
    check({tag, ".full"},     32'(push_if.full),     32'(mq.size() == DEPTH));
    check({tag, ".overflow"}, 32'(push_if.overflow), 32'(exp_ovf));
  endtask

  task automatic step(input logic we, input logic [7:0] d, input string tag);
    push_if.wr_en   = we;
    push_if.wr_data = d;
    @(posedge clk);
    model_edge(we, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    int busy_n;
    int n;
    logic [9:0] line;
    logic [7:0] r;

    reset_n         = 1'b0;
    push_if.wr_en   = 1'b0;
    push_if.wr_data = 8'h00;
    model_clear();

    // Reset state, then a quiet idle line
    repeat (3) step(1'b0, 8'h00, "reset");
    reset_n = 1'b1;
    repeat (50) step(1'b0, 8'h00, "idle");

    // Single byte 0xA5: latency, bit pattern and busy length
    step(1'b1, 8'hA5, "a5_push");
    check("a5_count1", 32'(push_if.count), 32'd1);
    check("a5_tx_still_high", 32'(tx), 32'd1);
    busy_n = 0;
    line   = '0;
    step(1'b0, 8'h00, "a5");
    check("a5_tx_fall", 32'(tx), 32'd0);
    for (int i = 0; i < 2 * FRAME && busy; i++) begin
      if ((busy_n % DIV) == DIV / 2) line[busy_n / DIV] = tx;
      busy_n++;
      step(1'b0, 8'h00, "a5");
    end
    check("a5_busy_len", 32'(busy_n), 32'(FRAME));
    check("a5_line", 32'(line), 32'({1'b1, 8'hA5, 1'b0}));
    check("a5_empty", 32'(push_if.empty), 32'd1);
    repeat (5) step(1'b0, 8'h00, "gap");

    // Three consecutive pushes: frames back to back
    busy_n = 0;
    step(1'b1, 8'h55, "b2b");
    step(1'b1, 8'h0F, "b2b");
    if (busy) busy_n++;
    step(1'b1, 8'hFF, "b2b");
    if (busy) busy_n++;
    for (int i = 0; i < 4 * FRAME && busy; i++) begin
      step(1'b0, 8'h00, "b2b");
      if (busy) busy_n++;
    end
    check("b2b_busy_len", 32'(busy_n), 32'(3 * FRAME));
    repeat (5) step(1'b0, 8'h00, "gap");

    // Six consecutive pushes while idle: fill to full, sixth overflows
    busy_n = 0;
    for (int i = 0; i < 6; i++) begin
      r = 8'($urandom);
      step(1'b1, r, "fill");
      if (busy) busy_n++;
      if (i == 4) begin
        check("fill_full", 32'(push_if.full), 32'd1);
        check("fill_count4", 32'(push_if.count), 32'd4);
      end
      if (i == 5) begin
        check("fill_ovf_pulse", 32'(push_if.overflow), 32'd1);
        check("fill_count_hold", 32'(push_if.count), 32'd4);
      end
    end
    step(1'b0, 8'h00, "fill");
    if (busy) busy_n++;
    check("fill_ovf_clear", 32'(push_if.overflow), 32'd0);
    for (int i = 0; i < 7 * FRAME && busy; i++) begin
      step(1'b0, 8'h00, "fill");
      if (busy) busy_n++;
    end
    check("fill_five_frames", 32'(busy_n), 32'(5 * FRAME));
    repeat (5) step(1'b0, 8'h00, "gap");

    // Reset mid-frame aborts immediately and nothing follows
    step(1'b1, 8'h3C, "abort");
    step(1'b0, 8'h00, "abort");
    repeat (45) step(1'b0, 8'h00, "abort");
    check("abort_busy_before", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(push_if.count), 32'd0);
    check("abort_empty", 32'(push_if.empty), 32'd1);
    repeat (3) step(1'b0, 8'h00, "abort_rst");
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      step(1'b0, 8'h00, "after_abort");
      if (busy || !tx) n++;
    end
    check("abort_no_frame", 32'(n), 32'd0);

    // Push while full at the STOP-end pop is still rejected
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), "stoppop");
    check("stoppop_full", 32'(push_if.full), 32'd1);
    n = 0;
    while (frame_t != FRAME - 1 && n < 2 * FRAME) begin
      step(1'b0, 8'h00, "stoppop_wait");
      n++;
    end
    check("stoppop_reached", 32'(frame_t == FRAME - 1), 32'd1);
    step(1'b1, 8'($urandom), "stoppop");
    check("stoppop_ovf", 32'(push_if.overflow), 32'd1);
    check("stoppop_count3", 32'(push_if.count), 32'd3);
    check("stoppop_tx_start", 32'(tx), 32'd0);
    repeat (5 * FRAME) step(1'b0, 8'h00, "stoppop_drain");

    // Random pushes with random spacing, including bursts into a full FIFO
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) step(1'b1, 8'($urandom), "rand");
      end else begin
        step(1'b0, 8'h00, "rand");
      end
    end
    repeat (6 * FRAME) step(1'b0, 8'h00, "rand_drain");
    check("final_idle_busy", 32'(busy), 32'd0);
    check("final_empty", 32'(push_if.empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
